// File: rtl/apb_cmd_master.sv
// Single-outstanding APB initiator: turns a valid/ready command stream into APB
// setup/access transfers and returns read data or an error on a response stream.
module apb_cmd_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    // Handshakes: a beat transfers at a clk edge where valid & ready are both 1;
    // a producer holds valid and its payload stable until that edge.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [31:0]       xfer_count,
    output logic [15:0]       err_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam bit          LP_TMO_EN    = (TIMEOUT != 0);
    localparam logic [31:0] LP_WAIT_LAST = LP_TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;

    state_t              r_state;
    logic                r_psel;
    logic                r_penable;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;
    logic [31:0]         r_xfer_count;
    logic [15:0]         r_err_count;
    logic [31:0]         r_wait;

    logic w_timeout_hit;
    logic w_err_sat;
    logic w_unused;

    // r_wait holds the number of earlier not-ready ACCESS cycles, so the abort
    // fires on the TIMEOUT-th consecutive one.
    assign w_timeout_hit = LP_TMO_EN && (r_wait == LP_WAIT_LAST);
    assign w_err_sat     = (r_err_count == 16'hFFFF);
    assign w_unused      = &{1'b0, cmd_addr[1:0]};

    assign cmd_ready   = (r_state == ST_IDLE) & reset;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign paddr       = r_paddr;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign xfer_count  = r_xfer_count;
    assign err_count   = r_err_count;
    assign dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_xfer_count  <= '0;
            r_err_count   <= '0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_paddr  <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        r_pwrite <= cmd_write;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                        r_wait   <= '0;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over a timeout expiring in the same cycle.
                    if (pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_xfer_count  <= r_xfer_count + 32'd1;
                        if (pslverr && !w_err_sat) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        r_state       <= ST_RESP;
                    end else if (w_timeout_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_xfer_count  <= r_xfer_count + 32'd1;
                        if (!w_err_sat) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        r_state       <= ST_RESP;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios with literal expectations, then a
// randomized command/slave/backpressure mix checked by a transaction-level model.
module tb_apb_cmd_master;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] xfer_count;
    logic [15:0] err_count;
    logic [1:0]  dbg_state;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .xfer_count(xfer_count), .err_count(err_count), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Directed knobs read by the slave process
    bit          rand_mode = 0;
    int          cfg_waits = 0;
    bit          cfg_err = 0;
    logic [31:0] cfg_rdata = '0;
    bit          tb_rsp_ready = 1;

    // Model state: one outstanding transfer at most
    bit          m_started = 0;
    bit          m_busy = 0;
    int          m_age = 0;
    int          m_waits = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_write = 0;
    logic [31:0] m_xfer = '0;
    logic [15:0] m_err = '0;
    logic [33:0] exp_q[$];

    int          acc_cyc = 0;
    int          hs_cyc = 0;
    logic [31:0] last_setup_paddr = '0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=no-event required=event (cycle %0d)", name, cyc);
    endtask

    // ---------------- APB slave and response consumer ----------------
    initial begin
        int acc_n;
        int cur_waits;
        bit cur_err;
        logic [31:0] cur_rdata;
        int w;
        acc_n = 0; cur_waits = 0; cur_err = 0; cur_rdata = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0; rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            if (psel && !penable) begin
                if (rand_mode) begin
                    w = $urandom_range(0, 7);
                    cur_waits = (w == 7) ? 16 + $urandom_range(0, 4) : (w == 6) ? 15 : w;
                    cur_err   = ($urandom_range(0, 3) == 0);
                    cur_rdata = $urandom;
                end else begin
                    cur_waits = cfg_waits;
                    cur_err   = cfg_err;
                    cur_rdata = cfg_rdata;
                end
            end
            if (psel && penable) acc_n++;
            else acc_n = 0;
            if (psel && penable) pready = (acc_n > cur_waits);
            else pready = 1'($urandom_range(0, 1));
            if (pready && psel && penable) begin
                prdata  = cur_rdata;
                pslverr = cur_err;
            end else begin
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            rsp_ready = rand_mode ? ($urandom_range(0, 3) != 0) : tb_rsp_ready;
        end
    end

    // ---------------- behavioural model + compare ----------------
    initial forever begin
        bit in_apb;
        @(negedge clk);
        in_apb = m_busy && (exp_q.size() == 0);
        if (m_started) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy && rst_n));
            chk("psel", 64'(psel), 64'(in_apb));
            chk("penable", 64'(penable), 64'(in_apb && m_age >= 1));
            if (in_apb) begin
                chk("paddr", 64'(paddr), 64'(m_addr));
                chk("pwrite", 64'(pwrite), 64'(m_write));
                chk("pwdata", 64'(pwdata), 64'(m_wdata));
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0][31:0]));
                chk("rsp_err", 64'(rsp_err), 64'(exp_q[0][32]));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_q[0][33]));
            end
            chk("xfer_count", 64'(xfer_count), 64'(m_xfer));
            chk("err_count", 64'(err_count), 64'(m_err));
            if (rst_n) begin
                if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
                if (rsp_valid && rsp_ready) hs_cyc = cyc + 1;
                if (psel && !penable) last_setup_paddr = paddr;
            end
        end
        // Advance the model to what the coming edge must produce.
        if (!rst_n) begin
            m_started = 1;
            m_busy = 0;
            exp_q.delete();
            m_xfer = '0;
            m_err = '0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy  = 1;
                m_age   = 0;
                m_waits = 0;
                m_addr  = cmd_addr & 32'hFFFF_FFFC;
                m_write = cmd_write;
                m_wdata = cmd_wdata;
            end
        end else if (in_apb) begin
            if (m_age == 0) begin
                m_age = 1;
            end else if (pready) begin
                exp_q.push_back({1'b0, pslverr, m_write ? 32'd0 : prdata});
                m_xfer = m_xfer + 1;
                if (pslverr && m_err != 16'hFFFF) m_err = m_err + 1;
            end else if (TMO != 0 && m_waits + 1 == TMO) begin
                exp_q.push_back({1'b1, 1'b1, 32'd0});
                m_xfer = m_xfer + 1;
                if (m_err != 16'hFFFF) m_err = m_err + 1;
            end else begin
                m_waits++;
            end
        end else if (rsp_ready) begin
            void'(exp_q.pop_front());
            m_busy = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input bit keep);
        bit rdy;
        bit done;
        done = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        if (!done) fail("cmd_accept_wait");
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int en_cycles);
        bit ok;
        ok = 0;
        en_cycles = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
            else if (penable) en_cycles++;
        end
        if (!ok) fail("rsp_wait");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int en;
        bit seen;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_psel", 64'(psel), 0);
        chk("rst_penable", 64'(penable), 0);
        chk("rst_paddr", 64'(paddr), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_xfer", 64'(xfer_count), 0);
        chk("rst_err", 64'(err_count), 0);
        chk("rst_cmd_ready", 64'(cmd_ready), 1);
        step();

        // Write, zero wait states
        cfg_waits = 0; cfg_err = 0; tb_rsp_ready = 1;
        send_cmd(1'b1, 32'h3C, 32'h0000_1234, 1'b0);
        @(negedge clk);
        chk("t1_c1_psel", 64'(psel), 1);
        chk("t1_c1_penable", 64'(penable), 0);
        chk("t1_c1_paddr", 64'(paddr), 64'h3C);
        chk("t1_c1_pwdata", 64'(pwdata), 64'h1234);
        @(negedge clk);
        chk("t1_c2_penable", 64'(penable), 1);
        chk("t1_c2_paddr", 64'(paddr), 64'h3C);
        @(negedge clk);
        chk("t1_c3_rsp_valid", 64'(rsp_valid), 1);
        chk("t1_c3_psel", 64'(psel), 0);
        chk("t1_c3_err", 64'(rsp_err), 0);
        chk("t1_c3_rdata", 64'(rsp_rdata), 0);
        chk("t1_c3_xfer", 64'(xfer_count), 1);
        step();

        // Read with three wait states
        cfg_waits = 3; cfg_rdata = 32'hCAFE_0001;
        send_cmd(1'b0, 32'h58, 32'hFFFF_FFFF, 1'b0);
        wait_rsp(en);
        chk("t2_penable_cycles", 64'(en), 4);
        chk("t2_rdata", 64'(rsp_rdata), 64'hCAFE_0001);
        chk("t2_err", 64'(rsp_err), 0);
        step();

        // Timeout, then pready arriving in the last allowed cycle
        cfg_waits = 1000;
        send_cmd(1'b0, 32'h60, 32'h0, 1'b0);
        wait_rsp(en);
        chk("t3_penable_cycles", 64'(en), 16);
        chk("t3_psel", 64'(psel), 0);
        chk("t3_err", 64'(rsp_err), 1);
        chk("t3_timeout", 64'(rsp_timeout), 1);
        chk("t3_rdata", 64'(rsp_rdata), 0);
        chk("t3_err_count", 64'(err_count), 1);
        chk("t3_xfer", 64'(xfer_count), 3);
        step();
        cfg_waits = 15; cfg_rdata = 32'h600D_F00D;
        send_cmd(1'b0, 32'h64, 32'h0, 1'b0);
        wait_rsp(en);
        chk("t3b_penable_cycles", 64'(en), 16);
        chk("t3b_timeout", 64'(rsp_timeout), 0);
        chk("t3b_err", 64'(rsp_err), 0);
        chk("t3b_rdata", 64'(rsp_rdata), 64'h600D_F00D);
        chk("t3b_err_count", 64'(err_count), 1);
        step();

        // Slave error with response backpressure
        cfg_waits = 0; cfg_err = 1; cfg_rdata = 32'h0BAD_0BAD; tb_rsp_ready = 0;
        send_cmd(1'b0, 32'h4C, 32'h0, 1'b0);
        wait_rsp(en);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            chk("t4_rsp_valid", 64'(rsp_valid), 1);
            chk("t4_cmd_ready", 64'(cmd_ready), 0);
            chk("t4_rdata", 64'(rsp_rdata), 64'h0BAD_0BAD);
            chk("t4_err", 64'(rsp_err), 1);
            chk("t4_timeout", 64'(rsp_timeout), 0);
        end
        step();
        tb_rsp_ready = 1;
        step();
        @(negedge clk);
        chk("t4_done_valid", 64'(rsp_valid), 0);
        chk("t4_err_count", 64'(err_count), 2);
        chk("t4_xfer", 64'(xfer_count), 5);
        step();

        // Unaligned address, second command waiting behind it
        cfg_err = 0;
        send_cmd(1'b1, 32'h57, 32'hA5A5_0000, 1'b1);
        send_cmd(1'b0, 32'h100, 32'h0, 1'b0);
        chk("t5_paddr_aligned", 64'(last_setup_paddr), 64'h54);
        chk("t5_b2b_gap", 64'(acc_cyc - hs_cyc), 1);
        wait_rsp(en);
        chk("t5_xfer", 64'(xfer_count), 7);
        step();

        // Reset in the middle of ACCESS
        cfg_waits = 1000;
        send_cmd(1'b0, 32'h20, 32'h0, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (penable) seen = 1;
        end
        if (!seen) fail("t6_penable_wait");
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_psel", 64'(psel), 0);
        chk("t6_penable", 64'(penable), 0);
        chk("t6_rsp_valid", 64'(rsp_valid), 0);
        chk("t6_xfer", 64'(xfer_count), 0);
        chk("t6_err", 64'(err_count), 0);
        cfg_waits = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("t6_no_response", 64'(seen), 0);
        step();

        // Randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) step();
            send_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 5)) step();
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (!m_busy) seen = 1;
        end
        if (!seen) fail("drain_wait");
        rand_mode = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
